// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one saturating 16-bit add/sub unit
// between two requesters, with a registered valid/ready result and an overflow counter.
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        ovfl,
    output logic        cout
);
    logic [15:0] bx, g, p;
    logic [16:0] c;
    logic [4:0]  gc;
    // 4-bit groups: group carries come from lookahead terms, inner bits ripple
    always_comb begin
        bx = sub ? ~b : b;
        g = a & bx;
        p = a ^ bx;
        gc = '0;
        c = '0;
        gc[0] = sub;
        for (int k = 0; k < 4; k++)
            gc[k+1] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                    | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]) | ((&p[4*k+:4]) & gc[k]);
        c[0] = sub;
        for (int i = 0; i < 16; i++)
            c[i+1] = (i % 4 == 3) ? gc[i/4+1] : g[i] | (p[i] & c[i]);
    end
    assign ovfl = c[16] ^ c[15];
    assign cout = c[16];
    // on overflow both operands share a sign, so a's sign picks the rail
    assign sum  = ovfl ? (a[15] ? 16'h8000 : 16'h7FFF) : p ^ c[15:0];
endmodule

module addsub_arbiter #(
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [15:0]          a0,
    input  logic [15:0]          b0,
    input  logic                 sub0,
    input  logic                 req1,
    input  logic [15:0]          a1,
    input  logic [15:0]          b1,
    input  logic                 sub1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [15:0]          res,
    output logic                 res_ovfl,
    output logic                 res_cout,
    output logic                 res_id,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OVF_CNT_W-1:0] ovf_cnt,
    input  logic                 ovf_clr
);
    typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;
    state_t      state, next;
    logic        ptr, grant, win, op_sub, op_id;
    logic [15:0] op_a, op_b, sum;
    logic        ovfl, cout;

    CLA_16bit u_cla (.a(op_a), .b(op_b), .sub(op_sub), .sum(sum), .ovfl(ovfl), .cout(cout));

    always_comb begin
        grant = (state == IDLE || (state == RESULT && res_ready)) && (req0 || req1);
        win = (req0 && req1) ? ptr : req1;
        next = state == EXEC ? RESULT :
               grant ? EXEC :
               (state == RESULT && !res_ready) ? RESULT : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= 1'b0;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            op_a <= '0;
            op_b <= '0;
            op_sub <= 1'b0;
            op_id <= 1'b0;
            res <= '0;
            res_ovfl <= 1'b0;
            res_cout <= 1'b0;
            res_id <= 1'b0;
            res_valid <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            state <= next;
            gnt0 <= grant && !win;
            gnt1 <= grant && win;
            if (grant) begin
                op_a <= win ? a1 : a0;
                op_b <= win ? b1 : b0;
                op_sub <= win ? sub1 : sub0;
                op_id <= win;
                ptr <= !win;
            end
            if (state == EXEC) begin
                res <= sum;
                res_ovfl <= ovfl;
                res_cout <= cout;
                res_id <= op_id;
                res_valid <= 1'b1;
            end else if (state == RESULT && res_ready)
                res_valid <= 1'b0;
            ovf_cnt <= ovf_clr ? '0 :
                       (res_valid && res_ready && res_ovfl && !(&ovf_cnt)) ? ovf_cnt + 1'b1 : ovf_cnt;
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed checks of arbitration, handshakes, saturation and overflow counting.
// A 4-bit counter keeps the saturation test short.
module tb_addsub_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 0, sub0 = 0, req1 = 0, sub1 = 0, res_ready = 0, ovf_clr = 0;
    logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic        gnt0, gnt1, res_ovfl, res_cout, res_id, res_valid;
    logic [15:0] res;
    logic [3:0]  ovf_cnt;
    int          n_chk = 0, n_err = 0;

    addsub_arbiter #(.OVF_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
        .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
        .gnt0(gnt0), .gnt1(gnt1),
        .res(res), .res_ovfl(res_ovfl), .res_cout(res_cout), .res_id(res_id),
        .res_valid(res_valid), .res_ready(res_ready),
        .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b, input logic s);
        if (id) begin req1 = 1; a1 = a; b1 = b; sub1 = s; end
        else begin req0 = 1; a0 = a; b0 = b; sub0 = s; end
        tick();
        req0 = 0;
        req1 = 0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", res_valid, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_res", res, 0);
        chk("rst_cnt", ovf_cnt, 0);
        rst_n = 1;
        tick();

        // simple add from requester 0
        res_ready = 1;
        req0 = 1; a0 = 16'h1234; b0 = 16'h0011; sub0 = 0;
        tick();
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        chk("t1_nvalid", res_valid, 0);
        req0 = 0;
        tick();
        chk("t1_valid", res_valid, 1);
        chk("t1_res", res, 16'h1245);
        chk("t1_ovfl", res_ovfl, 0);
        chk("t1_id", res_id, 0);
        tick();
        chk("t1_idle", res_valid, 0);

        // positive then negative saturation
        req1 = 1; a1 = 16'h7FFF; b1 = 16'h0001; sub1 = 0;
        tick();
        chk("t2_gnt1", gnt1, 1);
        req1 = 0;
        tick();
        chk("t2_res", res, 16'h7FFF);
        chk("t2_ovfl", res_ovfl, 1);
        chk("t2_cout", res_cout, 0);
        chk("t2_id", res_id, 1);
        chk("t2_cnt0", ovf_cnt, 0);
        tick();
        chk("t2_cnt1", ovf_cnt, 1);
        req0 = 1; a0 = 16'h8000; b0 = 16'h0001; sub0 = 1;
        tick();
        chk("t2b_gnt0", gnt0, 1);
        req0 = 0;
        tick();
        chk("t2b_res", res, 16'h8000);
        chk("t2b_ovfl", res_ovfl, 1);
        chk("t2b_cout", res_cout, 1);
        tick();
        chk("t2b_cnt2", ovf_cnt, 2);

        // alternating round-robin with both requesters held high
        do_reset();
        req0 = 1; a0 = 16'h0001; b0 = 16'h0002; sub0 = 0;
        req1 = 1; a1 = 16'h0010; b1 = 16'h0003; sub1 = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", {gnt1, gnt0}, k % 2 ? 2'b10 : 2'b01);
            chk("rr_gap", res_valid, 0);
            tick();
            chk("rr_valid", res_valid, 1);
            chk("rr_id", res_id, k % 2);
            chk("rr_res", res, k % 2 ? 16'h000D : 16'h0003);
            chk("rr_cout", res_cout, k % 2);
        end
        req0 = 0;
        req1 = 0;
        tick();
        chk("rr_end_valid", res_valid, 0);
        chk("rr_end_gnt", {gnt0, gnt1}, 0);

        // backpressure with requester 1 pending
        res_ready = 0;
        req0 = 1; a0 = 16'h0100; b0 = 16'h0001; sub0 = 1;
        tick();
        chk("bp_gnt0", gnt0, 1);
        req0 = 0;
        req1 = 1; a1 = 16'h7000; b1 = 16'h7000; sub1 = 0;
        tick();
        chk("bp_valid", res_valid, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_res", res, 16'h00FF);
            chk("bp_hold_id", res_id, 0);
            chk("bp_no_gnt1", gnt1, 0);
        end
        res_ready = 1;
        tick();
        chk("bp_gnt1", gnt1, 1);
        chk("bp_drop", res_valid, 0);
        req1 = 0;
        tick();
        chk("bp_res1", res, 16'h7FFF);
        chk("bp_id1", res_id, 1);
        chk("bp_ovfl1", res_ovfl, 1);
        tick();
        chk("bp_cnt", ovf_cnt, 1);

        // asynchronous reset during EXEC
        req0 = 1; a0 = 16'h0005; b0 = 16'h0005; sub0 = 0;
        tick();
        chk("ar_gnt0", gnt0, 1);
        req0 = 0;
        rst_n = 0;
        #1;
        chk("ar_gnt0_clr", gnt0, 0);
        chk("ar_res", res, 0);
        chk("ar_id", res_id, 0);
        chk("ar_ovfl", res_ovfl, 0);
        chk("ar_valid", res_valid, 0);
        chk("ar_cnt", ovf_cnt, 0);
        tick();
        rst_n = 1;
        tick();
        chk("ar_killed1", res_valid, 0);
        tick();
        chk("ar_killed2", res_valid, 0);
        req0 = 1; a0 = 16'h0005; b0 = 16'h0003; sub0 = 1;
        tick();
        chk("ar_fresh_gnt", gnt0, 1);
        req0 = 0;
        tick();
        chk("ar_fresh_res", res, 16'h0002);
        chk("ar_fresh_valid", res_valid, 1);
        tick();

        // counter saturation and clear priority
        for (int k = 0; k < 14; k++) run_op(0, 16'h7FFF, 16'h0001, 0);
        chk("sat_E", ovf_cnt, 4'hE);
        run_op(1, 16'h8000, 16'h8000, 0);
        chk("sat_F", ovf_cnt, 4'hF);
        run_op(0, 16'h7FFF, 16'h0001, 0);
        chk("sat_hold", ovf_cnt, 4'hF);
        res_ready = 0;
        req0 = 1; a0 = 16'h7FFF; b0 = 16'h0002; sub0 = 0;
        tick();
        req0 = 0;
        tick();
        chk("clr_ovfl", res_ovfl, 1);
        ovf_clr = 1;
        res_ready = 1;
        tick();
        chk("clr_prio", ovf_cnt, 0);
        ovf_clr = 0;
        tick();
        chk("clr_stay", ovf_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
